tb_rtrn_delay: RTL and testbench
================================

// Module: tb_rtrn_delay
// PURPOSE
//  Return-path latency stage between the emulated memory return FIFO (dcache_rtrn_t
//  producer) and the wt dcache mem_rtrn_* inputs in the dcache testbench.
//  Buffers every return in order and releases each one exactly 1+lat_i cycles after
//  capture, to stress miss-unit and writebuffer timing. Neither side has
//  backpressure, so overflow is flagged, never stalled.
// PARAMETERS
//  Depth     8   entries in the delay FIFO; power of two, >=2
//  CntWidth  16  timestamp counter width; must exceed 8 (width of lat_i) + log2(Depth)
// PORTS
//  clk_i          in   1                clock
//  rst_ni         in   1                asynchronous reset, active-low
//  flush_i        in   1                synchronous discard of all stored entries
//  lat_i          in   8                extra latency in cycles; may change at any time
//  rtrn_vld_i     in   1                upstream return valid
//  rtrn_i         in   $bits(dcache_rtrn_t)  upstream return payload
//  rtrn_vld_o     out  1                return valid to dcache
//  rtrn_o         out  $bits(dcache_rtrn_t)  return payload to dcache (head entry)
//  occupancy_o    out  $clog2(Depth)+1  stored entries
//  overflow_o     out  1                sticky: a return was dropped
// BEHAVIOUR
//  - Reset: FIFO empty, cnt_q=0, rtrn_vld_o=0, occupancy_o=0, overflow_o=0, rtrn_o='0.
//  - cnt_q: free-running CntWidth counter, wraps. Each accepted entry stores
//    {payload, stamp=cnt_q}.
//  - age = (cnt_q - head.stamp) mod 2^CntWidth.
//  - rtrn_vld_o = ~empty & (age > lat_i) & ~flush_i. Combinational from flops and lat_i.
//  - rtrn_o = head payload.
//  - Pop: the head is popped whenever rtrn_vld_o=1; at most one pop per cycle.
//  - Order: strict FIFO. INV_REQ, LOAD_ACK and STORE_ACK are never reordered.
//  - Latency: an entry captured in cycle t with the queue ahead of it drained is
//    presented in cycle t+1+lat_i. lat_i=0 gives one cycle.
//  - Lowering lat_i makes queued entries eligible early; they still leave one per cycle.
//  - Raising lat_i holds the head until its age exceeds the new value.
//  - Push (rtrn_vld_i=1), normal case: accepted if count<Depth, or if count==Depth and
//    a pop occurs in the same cycle.
//  - Push when count==Depth with no pop: payload dropped, overflow_o<=1.
//    overflow_o stays set until reset.
//  - Push to an empty FIFO while lat_i=0: entry appears next cycle (no
//    same-cycle bypass).
//  - Simultaneous push+pop: count unchanged; pointers wrap modulo Depth.
//  - flush_i=1: all stored entries discarded and rtrn_vld_o forced 0 that cycle.
//    A push in the same cycle is accepted as the sole entry, stamped cnt_q.
//    overflow_o is unaffected.
//  - Counter wrap: handled by modular subtraction. Stamps never age beyond
//    Depth*(256+1) < 2^CntWidth.
//  - Reset mid-operation: all entries lost, outputs return to reset values next edge.
//  - Elaboration check: $fatal if Depth is not a power of two or CntWidth <= 8+$clog2(Depth).
// CONFIGURATION
//  TB_RTRN_DELAY_STATS_EN defined:
//   - adds ports hwm_o [$clog2(Depth):0] (occupancy high-water mark) and
//     fwd_cnt_o [31:0] (returns forwarded, saturating).
//   - Both are 0 at reset. Neither is cleared by flush_i.
//  Macro undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 lat_i=0, single LOAD_ACK at cycle 10 -> rtrn_vld_o=1 only at cycle 11, payload
//     identical, occupancy 1->0.
//  T2 lat_i=5, back-to-back returns at cycles 0..3 -> outputs at cycles 6..9 in order,
//     one per cycle.
//  T3 Depth=8, lat_i=255, 9 consecutive pushes -> 9th dropped, overflow_o=1 from the
//     next cycle, first 8 delivered unchanged.
//  T4 full FIFO with head eligible plus push in the same cycle -> accepted,
//     occupancy stays 8, overflow_o stays 0.
//  T5 lat_i=20 with 3 entries queued, lat_i->0 at cycle 5 -> entries leave on 3
//     consecutive cycles starting at cycle 5.
//  T6 flush_i with 4 entries and a simultaneous push of tid=3 -> next output is tid=3
//     after 1+lat_i cycles. With STATS_EN: hwm_o=4, fwd_cnt_o counts only the
//     delivered entry.

Source files
------------

// File: rtl/tb_rtrn_delay.sv
// Return-path latency stage for the wt dcache testbench: in-order FIFO that releases each
// return 1+lat_i cycles after capture. Define TB_RTRN_DELAY_STATS_EN for hwm_o/fwd_cnt_o.
package tb_rtrn_delay_pkg;

  typedef enum logic [1:0] {
    DCACHE_LOAD_ACK  = 2'd0,
    DCACHE_STORE_ACK = 2'd1,
    DCACHE_INV_REQ   = 2'd2
  } dcache_rtrn_type_t;

  typedef struct packed {
    dcache_rtrn_type_t rtype;
    logic [1:0]        tid;
    logic              inv_vld;
    logic [31:0]       data;
  } dcache_rtrn_t;

endpackage

module tb_rtrn_delay
  import tb_rtrn_delay_pkg::*;
#(
  parameter int unsigned Depth    = 8,
  parameter int unsigned CntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [7:0]              lat_i,
  input  logic                    rtrn_vld_i,
  input  dcache_rtrn_t            rtrn_i,
  output logic                    rtrn_vld_o,
  output dcache_rtrn_t            rtrn_o,
  output logic [$clog2(Depth):0]  occupancy_o,
  output logic                    overflow_o
`ifdef TB_RTRN_DELAY_STATS_EN
  ,
  output logic [$clog2(Depth):0]  hwm_o,
  output logic [31:0]             fwd_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned OW = AW + 1;

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0) || (CntWidth <= 8 + AW)) begin : g_param_chk
    $fatal(1, "tb_rtrn_delay: Depth must be a power of two >= 2 and CntWidth > 8+log2(Depth)");
  end

  dcache_rtrn_t        mem_q   [Depth];
  logic [CntWidth-1:0] stamp_q [Depth];
  logic [AW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [OW-1:0]       count_q, count_d;
  logic [CntWidth-1:0] cnt_q, age;
  logic                empty, full, pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == OW'(Depth));

  // Modular subtraction keeps age correct across counter wrap.
  assign age        = cnt_q - stamp_q[rd_ptr_q];
  assign rtrn_vld_o = ~empty & (age > CntWidth'(lat_i)) & ~flush_i;
  assign pop        = rtrn_vld_o;
  // A flush empties the queue, so a same-cycle push always fits.
  assign push       = rtrn_vld_i & (flush_i | ~full | pop);

  assign rtrn_o      = empty ? '0 : mem_q[rd_ptr_q];
  assign occupancy_o = count_q;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = OW'(push);
    end else if (push && !pop) begin
      count_d = count_q + OW'(1);
    end else if (!push && pop) begin
      count_d = count_q - OW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + CntWidth'(1);
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rtrn_vld_i && !push) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: rtrn_o is masked while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q]   <= rtrn_i;
      stamp_q[wr_ptr_q] <= cnt_q;
    end
  end

`ifdef TB_RTRN_DELAY_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_o     <= '0;
      fwd_cnt_o <= '0;
    end else begin
      if (count_d > hwm_o) begin
        hwm_o <= count_d;
      end
      if (pop && (fwd_cnt_o != '1)) begin
        fwd_cnt_o <= fwd_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tb_rtrn_delay.sv
// Directed bench for tb_rtrn_delay: scoreboard of expected payloads and delivery cycles,
// checked by a negedge monitor, plus directed occupancy/overflow/flush checks.
module tb_tb_rtrn_delay;
  import tb_rtrn_delay_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic [7:0]   lat_i;
  logic         rtrn_vld_i;
  dcache_rtrn_t rtrn_i;
  logic         rtrn_vld_o;
  dcache_rtrn_t rtrn_o;
  logic [3:0]   occupancy_o;
  logic         overflow_o;
`ifdef TB_RTRN_DELAY_STATS_EN
  logic [3:0]   hwm_o;
  logic [31:0]  fwd_cnt_o;
`endif

  tb_rtrn_delay #(.Depth(8), .CntWidth(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .lat_i       (lat_i),
    .rtrn_vld_i  (rtrn_vld_i),
    .rtrn_i      (rtrn_i),
    .rtrn_vld_o  (rtrn_vld_o),
    .rtrn_o      (rtrn_o),
    .occupancy_o (occupancy_o),
    .overflow_o  (overflow_o)
`ifdef TB_RTRN_DELAY_STATS_EN
    ,
    .hwm_o       (hwm_o),
    .fwd_cnt_o   (fwd_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    dcache_rtrn_t p;
    int           exp_cyc;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [63:0] pw(input dcache_rtrn_t p);
    logic [63:0] r;
    r = '0;
    r[$bits(dcache_rtrn_t)-1:0] = p;
    return r;
  endfunction

  function automatic dcache_rtrn_t mk(input dcache_rtrn_type_t rt, input logic [1:0] tid,
                                      input logic [31:0] data);
    dcache_rtrn_t p;
    p.rtype   = rt;
    p.tid     = tid;
    p.inv_vld = (rt == DCACHE_INV_REQ);
    p.data    = data;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every delivered return must match the oldest expected one, in payload and cycle.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rtrn_vld_o === 1'b1) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out observed=%0h expected=none", pw(rtrn_o));
      end
      if (sb.size() != 0) begin
        sb_t e;
        e = sb.pop_front();
        check("out_payload", pw(rtrn_o), pw(e.p));
        if (e.exp_cyc >= 0) check("out_cycle", 64'(cyc), 64'(e.exp_cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push1(input dcache_rtrn_t p, input int e);
    sb_t s;
    s.p = p;
    s.exp_cyc = e;
    rtrn_vld_i = 1'b1;
    rtrn_i = p;
    sb.push_back(s);
    step();
    rtrn_vld_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    check(tag, 64'(sb.size()), 64'(0));
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    #1;
    check("rst_occ", 64'(occupancy_o), 64'(0));
    check("rst_ovf", 64'(overflow_o), 64'(0));
    check("rst_vld", 64'(rtrn_vld_o), 64'(0));
    sb.delete();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    dcache_rtrn_t p;
    sb_t s;
    rst_ni = 1'b0;
    flush_i = 1'b0;
    lat_i = 8'd0;
    rtrn_vld_i = 1'b0;
    rtrn_i = '0;
    #1;
    check("reset_vld", 64'(rtrn_vld_o), 64'(0));
    check("reset_occ", 64'(occupancy_o), 64'(0));
    check("reset_ovf", 64'(overflow_o), 64'(0));
    check("reset_rtrn", pw(rtrn_o), 64'(0));
`ifdef TB_RTRN_DELAY_STATS_EN
    check("reset_hwm", 64'(hwm_o), 64'(0));
    check("reset_fwd", 64'(fwd_cnt_o), 64'(0));
`endif
    step();
    step();
    rst_ni = 1'b1;
    step();

    // T1: single LOAD_ACK, lat 0 -> visible exactly one cycle later
    lat_i = 8'd0;
    check("t1_occ0", 64'(occupancy_o), 64'(0));
    t = cyc;
    push1(mk(DCACHE_LOAD_ACK, 2'd1, 32'hA5A5_0001), t + 1);
    check("t1_occ1", 64'(occupancy_o), 64'(1));
    step();
    check("t1_occ_after", 64'(occupancy_o), 64'(0));
    wait_drain("t1_drain", 4);
    repeat (3) step();

    // T2: lat 5, four back-to-back returns
    lat_i = 8'd5;
    t = cyc;
    for (int k = 0; k < 4; k++)
      push1(mk(dcache_rtrn_type_t'(2'(k % 3)), 2'(k), 32'h2000 + 32'(k)), t + k + 6);
    wait_drain("t2_drain", 20);

    // T3: lat 255, ninth push into a full FIFO is dropped
    lat_i = 8'd255;
    t = cyc;
    for (int k = 0; k < 8; k++)
      push1(mk(DCACHE_STORE_ACK, 2'(k), 32'h3000 + 32'(k)), t + k + 256);
    check("t3_ovf_before", 64'(overflow_o), 64'(0));
    rtrn_vld_i = 1'b1;
    rtrn_i = mk(DCACHE_INV_REQ, 2'd3, 32'hDEAD_BEEF);
    step();
    rtrn_vld_i = 1'b0;
    check("t3_ovf_set", 64'(overflow_o), 64'(1));
    check("t3_occ_full", 64'(occupancy_o), 64'(8));
    wait_drain("t3_drain", 300);
    check("t3_ovf_sticky", 64'(overflow_o), 64'(1));
    repeat (3) step();

    // Reset with entries queued: all lost, nothing emerges later
    lat_i = 8'd50;
    for (int k = 0; k < 3; k++) push1(mk(DCACHE_LOAD_ACK, 2'(k), 32'h4000 + 32'(k)), -1);
    pulse_reset();
    repeat (60) step();
    check("rst_mid_occ", 64'(occupancy_o), 64'(0));

    // T4: full FIFO, eligible head and push in same cycle -> accepted
    lat_i = 8'd10;
    t = cyc;
    for (int k = 0; k < 8; k++)
      push1(mk(DCACHE_LOAD_ACK, 2'(k), 32'h5000 + 32'(k)), t + k + 11);
    step();
    step();
    step();
    check("t4_occ_full", 64'(occupancy_o), 64'(8));
    check("t4_head_vld", 64'(rtrn_vld_o), 64'(1));
    push1(mk(DCACHE_INV_REQ, 2'd0, 32'h5008), t + 22);
    check("t4_occ_kept", 64'(occupancy_o), 64'(8));
    check("t4_ovf_clear", 64'(overflow_o), 64'(0));
    wait_drain("t4_drain", 40);
    check("t4_occ_end", 64'(occupancy_o), 64'(0));

    // T5: lowering lat releases queued entries one per cycle
    lat_i = 8'd20;
    t = cyc;
    for (int k = 0; k < 3; k++)
      push1(mk(DCACHE_STORE_ACK, 2'(k), 32'h6000 + 32'(k)), t + 5 + k);
    step();
    step();
    lat_i = 8'd0;
    wait_drain("t5_drain", 10);

    // Raising lat holds the head until its age exceeds the new value
    lat_i = 8'd2;
    t = cyc;
    push1(mk(DCACHE_LOAD_ACK, 2'd2, 32'h7000), t + 7);
    lat_i = 8'd6;
    wait_drain("raise_drain", 15);

    // T6: flush with four entries plus a simultaneous push of tid 3
    pulse_reset();
    lat_i = 8'd30;
    for (int k = 0; k < 4; k++) push1(mk(DCACHE_LOAD_ACK, 2'(k), 32'h8000 + 32'(k)), -1);
    lat_i = 8'd0;
    flush_i = 1'b1;
    sb.delete();
    p = mk(DCACHE_LOAD_ACK, 2'd3, 32'h8888);
    s.p = p;
    s.exp_cyc = cyc + 1;
    sb.push_back(s);
    rtrn_vld_i = 1'b1;
    rtrn_i = p;
    #1;
    check("t6_flush_vld", 64'(rtrn_vld_o), 64'(0));
    step();
    flush_i = 1'b0;
    rtrn_vld_i = 1'b0;
    check("t6_occ", 64'(occupancy_o), 64'(1));
`ifdef TB_RTRN_DELAY_STATS_EN
    check("t6_hwm", 64'(hwm_o), 64'(4));
    check("t6_fwd_before", 64'(fwd_cnt_o), 64'(0));
`endif
    wait_drain("t6_drain", 5);
    step();
`ifdef TB_RTRN_DELAY_STATS_EN
    check("t6_fwd_after", 64'(fwd_cnt_o), 64'(1));
    check("t6_hwm_after", 64'(hwm_o), 64'(4));
`endif
    check("t6_ovf", 64'(overflow_o), 64'(0));
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
